jtag_tap_multi: RTL and testbench
=================================

Name: jtag_tap_multi

Overview:
- Next-generation JTAG TAP with the full 16-state IEEE 1149.1 controller built in and a parametrised IR length.
- Provides the mandatory IDCODE and BYPASS registers plus NUM_USER independent user data registers, each USER_LEN bits wide.
- Each user register has its own capture and update strobes, so one TAP can serve several on-chip debug or config clients.
- Sits at the chip boundary between the JTAG pins and the user logic; all user-side signals are in the tck domain.

Parameters:
- IR_LEN, 5: instruction register width, minimum 4.
- ID_PARTVER, 4'h0: IDCODE[31:28].
- ID_PARTNUM, 16'h0000: IDCODE[27:12].
- ID_MANF, 11'h000: IDCODE[11:1]. IDCODE[0] is fixed at 1.
- NUM_USER, 4: number of user data registers, 1..8.
- USER_LEN, 32: width of each user register, 1..64.
- USER_BASE_OP, 8: opcode of user register 0. Register k uses USER_BASE_OP+k. Elaboration error if USER_BASE_OP+NUM_USER-1 is at or above IDCODE_OP.

Ports:
- tck, input, 1: the single clock. All state changes on the rising edge; tdo/tdo_en change on the falling edge.
- trst, input, 1: synchronous, active-high reset, sampled on rising tck.
- tms, input, 1: test mode select.
- tdi, input, 1: test data in.
- tdo, output, 1: test data out.
- tdo_en, output, 1: high while tdo carries valid shift data.
- user_in, input, NUM_USER*USER_LEN: capture values. Register k uses slice [k*USER_LEN +: USER_LEN].
- user_out, output, NUM_USER*USER_LEN: update-latched values, same slicing as user_in.
- user_upd, output, NUM_USER: one-tck pulse per channel in Update-DR.
- user_cap, output, NUM_USER: one-tck pulse per channel in Capture-DR.
- tap_state, output, 4: current controller state, standard 1149.1 encoding (TLR=4'hF, RTI=4'hC, ShiftDR=4'h2, ShiftIR=4'hA, ...).

Behaviour:
- Opcodes: IDCODE_OP = all ones except LSB 0. BYPASS_OP = all ones. Any undefined opcode selects BYPASS.
- Reset (trst high at a rising edge), all values from the next edge:
  - state = Test-Logic-Reset; IR = IDCODE_OP.
  - user_out = 0; user_upd = 0; user_cap = 0.
  - tdo = 0 and tdo_en = 0, applied at the next falling edge.
- trst dominates tms in every state, including mid-Shift-DR. Partially shifted data is discarded and user_out is not updated.
- FSM:
  - Standard 16 states with TMS-driven transitions on the rising edge.
  - Five consecutive tms=1 edges reach Test-Logic-Reset from any state.
  - Test-Logic-Reset forces IR = IDCODE_OP on every edge spent there.
- IR path:
  - Capture-IR loads {0..0,1} (binary 0..01).
  - Shift-IR shifts LSB-first, tdi into the MSB.
  - Update-IR latches the new IR on the edge leaving Update-IR. A separate shadow register holds the active instruction, so the active instruction stays stable during Shift-IR.
- DR path (selected by the active IR):
  - Capture-DR loads the selected register:
    - IDCODE: {ID_PARTVER, ID_PARTNUM, ID_MANF, 1}.
    - BYPASS: 0.
    - User register k: user_in slice k.
  - Shift-DR shifts LSB-first, tdi into the MSB of the selected register.
  - Update-DR copies user shift register k to user_out slice k. IDCODE and BYPASS are never written.
- Strobes:
  - user_cap[k] is high for exactly the tck cycle the FSM is in Capture-DR with IR = USER_BASE_OP+k.
  - user_upd[k] likewise for Update-DR.
  - At most one bit of each vector is high at a time.
- TDO:
  - Registered on the falling tck edge.
  - Value = LSB of the selected shift register in Shift-DR/Shift-IR, else 0.
  - tdo_en is 1 exactly while in Shift-DR or Shift-IR, falling-edge aligned.
- Latency:
  - The first shifted bit appears on tdo at the falling edge after the Capture→Shift transition.
  - A USER_LEN-bit write completes after USER_LEN Shift-DR edges plus Exit1 and Update.
- Shift-DR longer than the register length recirculates tdi through the register, so the final value is the last USER_LEN bits shifted in.
- Pause-DR/Pause-IR hold shift contents unchanged indefinitely.

Optional Feature:
- Macro: JTAG_TAP_MULTI_USERCODE_EN.
- When defined:
  - Adds a 32-bit read-only USERCODE register at opcode IDCODE_OP-1.
  - Captures from a new input port usercode[31:0]; updates are ignored.
  - The elaboration check becomes USER_BASE_OP+NUM_USER-1 < IDCODE_OP-1.
- When undefined: no usercode port, and opcode IDCODE_OP-1 decodes as BYPASS.

Test Plan:
- Reset, then Shift-DR for 32 bits with ID_PARTVER=4'h1, ID_PARTNUM=16'hBEEF, ID_MANF=11'h07F → tdo stream equals 32'h1BEEF0FF LSB-first. tdo_en is high for exactly 32 falling edges.
- Load IR=all ones, shift 8'hC3 into DR followed by 1 extra bit → tdo output is 8'hC3 delayed by one bit, with a leading 0.
- IR=USER_BASE_OP+2, user_in slice 2 = 32'h12345678, shift in 32'hA5A5A5A5 → tdo reads 32'h12345678. user_out slice 2 = 32'hA5A5A5A5. user_cap[2] and user_upd[2] each pulse once; all other channels are unchanged.
- Shift-IR of IR_LEN bits after reset → tdo returns 0..01; shifting opcode 5'h1D (undefined) selects BYPASS.
- Assert trst for one edge midway through a 32-bit user shift → state=4'hF, IR=IDCODE_OP, user_out all zero, no user_upd pulse.
- With JTAG_TAP_MULTI_USERCODE_EN and usercode=32'hCAFEF00D, select IDCODE_OP-1 → tdo reads 32'hCAFEF00D; a write attempt leaves the readback unchanged.

Source files
------------

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP with IDCODE, BYPASS and NUM_USER user data registers, each with capture/update strobes.
// Optional 32-bit read-only USERCODE register at IDCODE_OP-1 when JTAG_TAP_MULTI_USERCODE_EN is defined.
module jtag_tap_multi #(
    parameter int          IR_LEN       = 5,
    parameter logic [3:0]  ID_PARTVER   = 4'h0,
    parameter logic [15:0] ID_PARTNUM   = 16'h0000,
    parameter logic [10:0] ID_MANF      = 11'h000,
    parameter int          NUM_USER     = 4,
    parameter int          USER_LEN     = 32,
    parameter int          USER_BASE_OP = 8
) (
    input  logic                         tck,
    input  logic                         trst,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    input  logic [NUM_USER*USER_LEN-1:0] user_in,
    output logic [NUM_USER*USER_LEN-1:0] user_out,
    output logic [NUM_USER-1:0]          user_upd,
    output logic [NUM_USER-1:0]          user_cap,
`ifdef JTAG_TAP_MULTI_USERCODE_EN
    input  logic [31:0]                  usercode,
`endif
    output logic [3:0]                   tap_state
);

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC,
        SEL_DR  = 4'h7, CAP_DR  = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
        PAU_DR  = 4'h3, EX2_DR  = 4'h0, UPD_DR  = 4'h5,
        SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
        PAU_IR  = 4'hB, EX2_IR  = 4'h8, UPD_IR  = 4'hD
    } state_t;

    typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_USER, SEL_UC} sel_t;

    localparam int                IDCODE_INT = (1 << IR_LEN) - 2;
    localparam logic [IR_LEN-1:0] IDCODE_OP  = IR_LEN'(IDCODE_INT);
    localparam logic [31:0]       IDCODE_VAL = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};
    localparam int                IDX_W      = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;
`ifdef JTAG_TAP_MULTI_USERCODE_EN
    localparam logic [IR_LEN-1:0] USERCODE_OP = IR_LEN'(IDCODE_INT - 1);
    localparam int                OP_LIMIT    = IDCODE_INT - 1;
`else
    localparam int                OP_LIMIT    = IDCODE_INT;
`endif

    if (IR_LEN < 4 || NUM_USER < 1 || NUM_USER > 8 || USER_LEN < 1 || USER_LEN > 64 ||
        USER_BASE_OP + NUM_USER - 1 >= OP_LIMIT) begin : g_bad_cfg
        $error("jtag_tap_multi: illegal parameter combination");
    end

    state_t              state;
    state_t              nxt;
    logic [IR_LEN-1:0]   ir;
    logic [IR_LEN-1:0]   ir_sr;
    logic [31:0]         dr32;
    logic                byp;
    logic [USER_LEN-1:0] user_sr;
    logic [USER_LEN:0]   user_cat;
    sel_t                sel;
    logic [IDX_W-1:0]    user_idx;
    logic [NUM_USER-1:0] user_hit;
    logic                dr_lsb;

    function automatic state_t next_state(input state_t s, input logic m);
        case (s)
            TLR:     next_state = m ? TLR    : RTI;
            RTI:     next_state = m ? SEL_DR : RTI;
            SEL_DR:  next_state = m ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = m ? EX1_DR : SH_DR;
            SH_DR:   next_state = m ? EX1_DR : SH_DR;
            EX1_DR:  next_state = m ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = m ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = m ? UPD_DR : SH_DR;
            UPD_DR:  next_state = m ? SEL_DR : RTI;
            SEL_IR:  next_state = m ? TLR    : CAP_IR;
            CAP_IR:  next_state = m ? EX1_IR : SH_IR;
            SH_IR:   next_state = m ? EX1_IR : SH_IR;
            EX1_IR:  next_state = m ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = m ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = m ? UPD_IR : SH_IR;
            UPD_IR:  next_state = m ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    endfunction

    assign nxt       = next_state(state, tms);
    assign tap_state = state;
    assign user_cat  = {tdi, user_sr};

    // Instruction decode from the active (shadow) IR; anything unrecognised is BYPASS.
    always_comb begin
        sel      = SEL_BYP;
        user_idx = '0;
        user_hit = '0;
        if (ir == IDCODE_OP) sel = SEL_ID;
`ifdef JTAG_TAP_MULTI_USERCODE_EN
        if (ir == USERCODE_OP) sel = SEL_UC;
`endif
        for (int k = 0; k < NUM_USER; k++) begin
            if (ir == IR_LEN'(USER_BASE_OP + k)) begin
                sel         = SEL_USER;
                user_idx    = IDX_W'(k);
                user_hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        dr_lsb = byp;
        case (sel)
            SEL_ID, SEL_UC: dr_lsb = dr32[0];
            SEL_USER:       dr_lsb = user_sr[0];
            default:        dr_lsb = byp;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            state    <= TLR;
            ir       <= IDCODE_OP;
            ir_sr    <= '0;
            dr32     <= '0;
            byp      <= 1'b0;
            user_sr  <= '0;
            user_out <= '0;
            user_cap <= '0;
            user_upd <= '0;
        end else begin
            state    <= nxt;
            // Strobes are registered from the next state so they align with the state itself.
            user_cap <= (nxt == CAP_DR) ? user_hit : '0;
            user_upd <= (nxt == UPD_DR) ? user_hit : '0;
            case (state)
                TLR:    ir    <= IDCODE_OP;
                CAP_IR: ir_sr <= IR_LEN'(1);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    case (sel)
                        SEL_ID:   dr32    <= IDCODE_VAL;
`ifdef JTAG_TAP_MULTI_USERCODE_EN
                        SEL_UC:   dr32    <= usercode;
`endif
                        SEL_USER: user_sr <= user_in[user_idx*USER_LEN +: USER_LEN];
                        default:  byp     <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (sel)
                        SEL_ID, SEL_UC: dr32    <= {tdi, dr32[31:1]};
                        SEL_USER:       user_sr <= user_cat[USER_LEN:1];
                        default:        byp     <= tdi;
                    endcase
                end
                UPD_DR: begin
                    if (sel == SEL_USER)
                        user_out[user_idx*USER_LEN +: USER_LEN] <= user_sr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck) begin
        tdo_en <= (state == SH_DR) || (state == SH_IR);
        if (state == SH_IR)      tdo <= ir_sr[0];
        else if (state == SH_DR) tdo <= dr_lsb;
        else                     tdo <= 1'b0;
    end

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed bench for jtag_tap_multi: drives TMS/TDI sequences, a monitor checks every tdo bit against a queue.
// Define JTAG_TAP_MULTI_USERCODE_EN for both files to exercise the USERCODE register.
module tb_jtag_tap_multi;
    localparam int NU = 4;
    localparam int UL = 32;

    logic             tck = 1'b0;
    logic             trst;
    logic             tms;
    logic             tdi;
    logic             tdo;
    logic             tdo_en;
    logic [NU*UL-1:0] user_in;
    logic [NU*UL-1:0] user_out;
    logic [NU-1:0]    user_upd;
    logic [NU-1:0]    user_cap;
    logic [3:0]       tap_state;
`ifdef JTAG_TAP_MULTI_USERCODE_EN
    logic [31:0]      usercode;
`endif

    int tests = 0;
    int fails = 0;
    int bit_no = 0;
    int cap_cnt[NU];
    int upd_cnt[NU];
    logic [0:0] exp_q[$];

    jtag_tap_multi #(
        .IR_LEN(5), .ID_PARTVER(4'h1), .ID_PARTNUM(16'hBEEF), .ID_MANF(11'h07F),
        .NUM_USER(NU), .USER_LEN(UL), .USER_BASE_OP(8)
    ) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .user_in(user_in), .user_out(user_out), .user_upd(user_upd), .user_cap(user_cap),
`ifdef JTAG_TAP_MULTI_USERCODE_EN
        .usercode(usercode),
`endif
        .tap_state(tap_state)
    );

    // clock and watchdog
    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // monitor: every bit presented with tdo_en is popped and compared
    always @(posedge tck) begin
        logic [0:0] e;
        if (tdo_en === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tdo_extra bit=%0d got %b required none", bit_no, tdo);
            end else begin
                e = exp_q.pop_front();
                if (tdo !== e[0]) begin
                    fails++;
                    $display("FAIL tdo_bit bit=%0d got %b required %b", bit_no, tdo, e[0]);
                end
            end
            bit_no++;
        end
    end

    always @(negedge tck) begin
        for (int k = 0; k < NU; k++) begin
            if (user_cap[k] === 1'b1) cap_cnt[k]++;
            if (user_upd[k] === 1'b1) upd_cnt[k]++;
        end
    end

    // driver tasks
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(negedge tck);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic push_bits(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NU; k++) begin
            cap_cnt[k] = 0;
            upd_cnt[k] = 0;
        end
    endtask

    // From Run-Test/Idle: shift a 5-bit opcode, expect the 0..01 capture pattern, return to RTI.
    task automatic shift_ir(input logic [4:0] op);
        push_bits(5, 64'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("state_shift_ir", 128'(tap_state), 128'hA);
        for (int i = 0; i < 5; i++) step(i == 4, op[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: shift n bits (optionally detouring through Pause-DR after pause_at bits), update, return to RTI.
    task automatic shift_dr(input int n, input logic [63:0] din, input logic [63:0] req, input int pause_at);
        push_bits(n, req);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("state_shift_dr", 128'(tap_state), 128'h2);
        for (int i = 0; i < n; i++) begin
            step((i == n - 1) || (i == pause_at - 1), din[i]);
            if (i == pause_at - 1 && i != n - 1) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b1);
                step(1'b0, 1'b1);
                check("state_pause_dr", 128'(tap_state), 128'h3);
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [3:0] tms5_seq [5];

    initial begin
        tms5_seq = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
        trst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        user_in = {32'h55AA33CC, 32'h12345678, 32'h0BADF00D, 32'hDEADBEEF};
`ifdef JTAG_TAP_MULTI_USERCODE_EN
        usercode = 32'hCAFEF00D;
`endif
        clear_counts();
        @(negedge tck);
        #1;
        step(1'b1, 1'b0);
        trst = 1'b0;

        check("reset_state", 128'(tap_state), 128'hF);
        check("reset_user_out", user_out, 128'h0);
        check("reset_user_cap", 128'(user_cap), 128'h0);
        check("reset_user_upd", 128'(user_upd), 128'h0);
        check("reset_tdo", 128'(tdo), 128'h0);
        check("reset_tdo_en", 128'(tdo_en), 128'h0);

        step(1'b0, 1'b0);
        check("state_rti", 128'(tap_state), 128'hC);

        // IDCODE selected after reset
        shift_dr(32, 64'h0, 64'h1BEEF0FF, 0);

        // BYPASS: 8'hC3 then one extra bit emerges one bit late behind a 0
        shift_ir(5'h1F);
        shift_dr(9, 64'h0C3, 64'h186, 0);

        // user register 2 read and write
        clear_counts();
        shift_ir(5'h0A);
        shift_dr(32, 64'hA5A5A5A5, 64'h12345678, 0);
        check("user_out_ch2", user_out, {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0});
        for (int k = 0; k < NU; k++) begin
            check($sformatf("cap_cnt%0d", k), 128'(cap_cnt[k]), (k == 2) ? 128'h1 : 128'h0);
            check($sformatf("upd_cnt%0d", k), 128'(upd_cnt[k]), (k == 2) ? 128'h1 : 128'h0);
        end

        // over-length shift into user 0: last 32 bits in are kept, tail of tdo is the first tdi bits
        shift_ir(5'h08);
        shift_dr(40, 64'h9C0F1E2D3C, 64'h3CDEADBEEF, 0);
        check("user_out_ch0", 128'(user_out[31:0]), 128'h9C0F1E2D);

        // user 1 with a Pause-DR detour mid-shift
        shift_ir(5'h09);
        shift_dr(32, 64'h600DCAFE, 64'h0BADF00D, 16);
        check("user_out_all", user_out, {32'h0, 32'hA5A5A5A5, 32'h600DCAFE, 32'h9C0F1E2D});

        // undefined opcode behaves as BYPASS
        shift_ir(5'h15);
        shift_dr(4, 64'hB, 64'h6, 0);

`ifdef JTAG_TAP_MULTI_USERCODE_EN
        shift_ir(5'h1D);
        shift_dr(32, 64'h12345678, 64'hCAFEF00D, 0);
        shift_dr(32, 64'h0, 64'hCAFEF00D, 0);
`else
        shift_ir(5'h1D);
        shift_dr(4, 64'h5, 64'hA, 0);
`endif
        check("user_out_hold", user_out, {32'h0, 32'hA5A5A5A5, 32'h600DCAFE, 32'h9C0F1E2D});

        // trst in the middle of a user shift
        clear_counts();
        shift_ir(5'h0A);
        push_bits(17, 64'h12345678);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        trst = 1'b1;
        step(1'b0, 1'b1);
        trst = 1'b0;
        check("abort_state", 128'(tap_state), 128'hF);
        check("abort_user_out", user_out, 128'h0);
        check("abort_tdo_en", 128'(tdo_en), 128'h0);
        check("abort_cap2", 128'(cap_cnt[2]), 128'h1);
        step(1'b0, 1'b0);
        shift_dr(32, 64'h0, 64'h1BEEF0FF, 0);
        for (int k = 0; k < NU; k++)
            check($sformatf("abort_upd%0d", k), 128'(upd_cnt[k]), 128'h0);

        // five tms=1 edges from Capture-DR reach Test-Logic-Reset
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("state_cap_dr", 128'(tap_state), 128'h6);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("tms5_state%0d", i), 128'(tap_state), 128'(tms5_seq[i]));
        end

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("exp_q_drained", 128'(exp_q.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
